// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial unsigned a - b, LSB first, with start/busy/done handshake.
// Revision : 1.0
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_bit;
  logic             diff_bit;
  logic             brw_next;

  assign last_bit = (cnt == LAST_BIT);

  // Full-subtract of the current operand LSBs with the registered borrow.
  assign diff_bit  = a_sh[0] ^ b_sh[0] ^ brw;
  assign brw_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
  // Result bits enter from the MSB side so the LSB lands at bit 0 after WIDTH steps.
  assign work_next = (work >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Working register keeps partial results private; diff/borrow_out load only at completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      work       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      brw  <= brw_next;
      work <= work_next;
      cnt  <= cnt + CNT_W'(1);
      if (last_bit) begin
        diff       <= work_next;
        borrow_out <= brw_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Scoreboard bench for serial_subtractor at WIDTH 8, 4 and 1.
// Revision : 1.0
// ============================================================================
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;
  logic       start4, busy4, done4, bo4;
  logic [3:0] a4, b4, diff4;
  logic       start1, busy1, done1, bo1;
  logic [0:0] a1, b1, diff1;

  int checks   = 0;
  int failures = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [1:0] q1[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );
  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );
  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if ({busy8, done8, bo8, diff8} !== 11'b0) begin
      failures++;
      $display("FAIL reset_w8: got busy=%b done=%b borrow=%b diff=%h, expected all zero", busy8, done8, bo8, diff8);
    end
    checks++;
    if ({busy4, done4, bo4, diff4} !== 7'b0) begin
      failures++;
      $display("FAIL reset_w4: got busy=%b done=%b borrow=%b diff=%h, expected all zero", busy4, done4, bo4, diff4);
    end
    checks++;
    if ({busy1, done1, bo1, diff1} !== 4'b0) begin
      failures++;
      $display("FAIL reset_w1: got busy=%b done=%b borrow=%b diff=%h, expected all zero", busy1, done1, bo1, diff1);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] va[4] = '{8'h05, 8'h03, 8'h00, 8'hFF};
    logic [7:0] vb[4] = '{8'h03, 8'h05, 8'hFF, 8'hFF};
    logic [8:0] held;
    logic [8:0] expv;
    for (int v = 0; v < 4; v++) begin
      held   = {bo8, diff8};
      a8     = va[v];
      b8     = vb[v];
      start8 = 1'b1;
      q8.push_back({(va[v] < vb[v]), 8'(va[v] - vb[v])});
      step();
      start8 = 1'b0;
      a8     = 8'h5A;
      b8     = 8'hC3;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0 || {bo8, diff8} !== held) begin
          failures++;
          $display("FAIL basic_shift: op %0d cycle %0d got busy=%b done=%b out=%h, expected busy=1 done=0 out=%h",
                   v, i, busy8, done8, {bo8, diff8}, held);
        end
        step();
      end
      expv = q8.pop_front();
      checks++;
      if (done8 !== 1'b1 || busy8 !== 1'b0) begin
        failures++;
        $display("FAIL basic_done: op %0d got busy=%b done=%b, expected busy=0 done=1", v, busy8, done8);
      end
      checks++;
      if ({bo8, diff8} !== expv) begin
        failures++;
        $display("FAIL basic_result: op %0d got borrow=%b diff=%h, expected borrow=%b diff=%h",
                 v, bo8, diff8, expv[8], expv[7:0]);
      end
      step();
      checks++;
      if (done8 !== 1'b0 || {bo8, diff8} !== expv) begin
        failures++;
        $display("FAIL basic_hold: op %0d got done=%b out=%h, expected done=0 out=%h", v, done8, {bo8, diff8}, expv);
      end
    end
  endtask

  task automatic test_sweep_w4();
    int         idx      = 1;
    int         done_cnt = 0;
    int         gap      = 0;
    int         cycles   = 0;
    logic [4:0] expv;
    a4     = 4'h0;
    b4     = 4'h0;
    start4 = 1'b1;
    q4.push_back(5'b0);
    while (done_cnt < 256 && cycles < 2000) begin
      step();
      cycles++;
      gap++;
      if (done4 === 1'b1) begin
        expv = q4.pop_front();
        checks++;
        if ({bo4, diff4} !== expv) begin
          failures++;
          $display("FAIL sweep_result: op %0d got borrow=%b diff=%h, expected borrow=%b diff=%h",
                   done_cnt, bo4, diff4, expv[4], expv[3:0]);
        end
        checks++;
        if (gap != 5) begin
          failures++;
          $display("FAIL sweep_gap: op %0d got %0d cycles between dones, expected 5", done_cnt, gap);
        end
        done_cnt++;
        gap = 0;
        if (idx < 256) begin
          a4 = idx[7:4];
          b4 = idx[3:0];
          q4.push_back({(a4 < b4), 4'(a4 - b4)});
          idx++;
        end else begin
          start4 = 1'b0;
        end
      end
    end
    start4 = 1'b0;
    checks++;
    if (done_cnt != 256) begin
      failures++;
      $display("FAIL sweep_count: got %0d results, expected 256", done_cnt);
    end
    step();
  endtask

  task automatic test_start_ignored();
    logic [8:0] held;
    logic [8:0] expv;
    held   = {bo8, diff8};
    a8     = 8'hA0;
    b8     = 8'h01;
    start8 = 1'b1;
    q8.push_back({1'b0, 8'h9F});
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0 || {bo8, diff8} !== held) begin
        failures++;
        $display("FAIL ignore_shift: cycle %0d got busy=%b done=%b out=%h, expected busy=1 done=0 out=%h",
                 i, busy8, done8, {bo8, diff8}, held);
      end
      if (i < 3) begin
        start8 = 1'b1;
        a8     = 8'h00;
        b8     = 8'h00;
      end else begin
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
      end
      step();
    end
    expv = q8.pop_front();
    checks++;
    if (done8 !== 1'b1 || {bo8, diff8} !== expv) begin
      failures++;
      $display("FAIL ignore_result: got done=%b borrow=%b diff=%h, expected done=1 borrow=%b diff=%h",
               done8, bo8, diff8, expv[8], expv[7:0]);
    end
    step();
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL ignore_after: got busy=%b done=%b, expected busy=0 done=0", busy8, done8);
    end
  endtask

  task automatic test_reset_abort();
    logic [8:0] expv;
    int         waited;
    a8     = 8'h10;
    b8     = 8'h20;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    checks++;
    if ({busy8, done8, bo8, diff8} !== 11'b0) begin
      failures++;
      $display("FAIL abort_reset: got busy=%b done=%b borrow=%b diff=%h, expected all zero", busy8, done8, bo8, diff8);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet: cycle %0d got busy=%b done=%b, expected busy=0 done=0", i, busy8, done8);
      end
    end
    a8     = 8'h09;
    b8     = 8'h04;
    start8 = 1'b1;
    q8.push_back({1'b0, 8'h05});
    step();
    start8 = 1'b0;
    waited = 1;
    while (done8 !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    expv = q8.pop_front();
    checks++;
    if (done8 !== 1'b1 || waited != 9) begin
      failures++;
      $display("FAIL abort_latency: got done=%b after %0d edges, expected done=1 after 9", done8, waited);
    end
    checks++;
    if ({bo8, diff8} !== expv) begin
      failures++;
      $display("FAIL abort_result: got borrow=%b diff=%h, expected borrow=%b diff=%h", bo8, diff8, expv[8], expv[7:0]);
    end
    step();
  endtask

  task automatic test_width1();
    logic [0:0] va[2] = '{1'b0, 1'b1};
    logic [0:0] vb[2] = '{1'b1, 1'b0};
    logic [1:0] held;
    logic [1:0] expv;
    for (int v = 0; v < 2; v++) begin
      held   = {bo1, diff1};
      a1     = va[v];
      b1     = vb[v];
      start1 = 1'b1;
      q1.push_back({(va[v] < vb[v]), 1'(va[v] - vb[v])});
      step();
      start1 = 1'b0;
      a1     = ~a1;
      b1     = ~b1;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0 || {bo1, diff1} !== held) begin
        failures++;
        $display("FAIL w1_shift: op %0d got busy=%b done=%b out=%b, expected busy=1 done=0 out=%b",
                 v, busy1, done1, {bo1, diff1}, held);
      end
      step();
      expv = q1.pop_front();
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || {bo1, diff1} !== expv) begin
        failures++;
        $display("FAIL w1_result: op %0d got busy=%b done=%b borrow=%b diff=%b, expected busy=0 done=1 borrow=%b diff=%b",
                 v, busy1, done1, bo1, diff1, expv[1], expv[0]);
      end
      step();
      checks++;
      if (done1 !== 1'b0 || {bo1, diff1} !== expv) begin
        failures++;
        $display("FAIL w1_hold: op %0d got done=%b out=%b, expected done=0 out=%b", v, done1, {bo1, diff1}, expv);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_sweep_w4();
    test_start_ignored();
    test_reset_abort();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor computing a − b, one bit per clock, LSB first.
- Each bit step is a full-subtract: diff = a_i ^ b_i ^ brw; brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw).
- A registered borrow carries each step's outborrow into the next step as its inborrow.
- Sits beside the combinational half/full subtractors as the area-cheap multi-bit consumer of the borrow chain.
- Start/busy/done handshake to a controlling block.

Parameters:
- WIDTH, 8: operand and result width in bits. Legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when the result is valid.
- diff  output  WIDTH  result a − b mod 2^WIDTH; held until the next accept.
- borrow_out  output  1  final borrow; 1 iff a < b unsigned; held with diff.

Behaviour:
- Reset: synchronous, active-low, one clock, single clock domain.
  - rst_n low at an edge → state IDLE, busy=0, done=0, diff=0, borrow_out=0, internal borrow=0, bit counter=0.
  - Reset has priority over start and over any in-progress operation.
  - Reset mid-SHIFT aborts the operation; no done pulse is produced.
- States: IDLE, SHIFT, DONE. State encoding is free.
- IDLE, or DONE, with start=1 at edge k:
  - Capture a and b into shift registers; clear internal borrow; counter=0.
  - Go to SHIFT: busy=1, done=0.
  - diff and borrow_out keep their previous values until completion.
- SHIFT, each edge k+1 .. k+WIDTH:
  - Take the operand LSBs and the registered borrow.
  - Shift the difference bit into the result register from the MSB side.
  - Shift both operand registers right by one; update the borrow register; counter+1.
- Completion at edge k+WIDTH:
  - diff holds the full result; borrow_out = final borrow.
  - State DONE: busy=0, done=1.
- DONE → IDLE on the next edge unless start=1, in which case a new operation is accepted (back-to-back).
  - done falls after one cycle in either case.
- Latency: done is high during the cycle after edge k+WIDTH.
  - Accept-to-done is WIDTH+1 edges from the edge that sampled start.
  - Throughput is one operation per WIDTH+1 cycles.
- Start during SHIFT is ignored. Captured operands are unaffected by changes on a/b after the accept edge.
- diff and borrow_out must not show partial values externally during SHIFT.
  - Keep a separate working register, or update the outputs only at completion.
- WIDTH=1: SHIFT lasts exactly one edge; behaviour is otherwise identical.
- Arithmetic: unsigned, modulo 2^WIDTH. No signed-overflow output.

Test Plan:
1. WIDTH=8, reset, then start with a=8'h05, b=8'h03 → busy for 8 cycles; done pulses once at accept+9 edges; diff=8'h02, borrow_out=0; both hold after done.
2. a=8'h03, b=8'h05 → diff=8'hFE, borrow_out=1. Then a=8'h00, b=8'hFF → diff=8'h01, borrow_out=1. Then a=8'hFF, b=8'hFF → diff=8'h00, borrow_out=0.
3. Exhaustive WIDTH=4 sweep of all 256 (a,b) pairs, issued back-to-back by asserting start in the DONE cycle → every diff=(a−b)&4'hF, borrow_out=(a<b); no idle cycle between operations.
4. Start a=8'hA0, b=8'h01; pulse start again with a=8'h00, b=8'h00 and change a/b during SHIFT → the second start is ignored; result diff=8'h9F, borrow_out=0.
5. Start a=8'h10, b=8'h20; drive rst_n low at the 4th SHIFT edge → next edge busy=0, done=0, diff=0, borrow_out=0; no done pulse appears. A following op a=8'h09, b=8'h04 gives diff=8'h05.
6. WIDTH=1: a=0, b=1 → done at accept+2 edges, diff=1, borrow_out=1. a=1, b=0 → diff=1, borrow_out=0.
